// File: rtl/gemm_pkg.sv
// Shared widths and FSM encoding for the GEMM sequencer slice.
// Element widths follow the gemm_op core that this sequencer feeds.
package gemm_pkg;
  localparam int INP_WIDTH = 8;
  localparam int WGT_WIDTH = 8;
  localparam int ACC_WIDTH = 32;
  localparam int BLOCK     = 16;
  localparam int IT_WIDTH  = INP_WIDTH * BLOCK;
  localparam int WT_WIDTH  = WGT_WIDTH * BLOCK * BLOCK;
  localparam int AT_WIDTH  = ACC_WIDTH * BLOCK;

  localparam int INP_AW = 11;
  localparam int WGT_AW = 10;
  localparam int ACC_AW = 11;
  localparam int CNT_W  = 14;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DRAIN,
    ST_DONE
  } gemm_state_e;
endpackage

// File: rtl/gemm_seq_if.sv
// Control, configuration and SRAM/gemm_op signals of the GEMM sequencer.
// slave is the sequencer side; master is the load/store stage and SRAM side.
interface gemm_seq_if #(
  parameter int INP_AW   = gemm_pkg::INP_AW,
  parameter int WGT_AW   = gemm_pkg::WGT_AW,
  parameter int ACC_AW   = gemm_pkg::ACC_AW,
  parameter int CNT_W    = gemm_pkg::CNT_W,
  parameter int AT_WIDTH = gemm_pkg::AT_WIDTH
);
  logic                start;
  logic [CNT_W-1:0]    cfg_iters;
  logic [INP_AW-1:0]   cfg_inp_base;
  logic [INP_AW-1:0]   cfg_inp_stride;
  logic [WGT_AW-1:0]   cfg_wgt_base;
  logic [WGT_AW-1:0]   cfg_wgt_stride;
  logic [ACC_AW-1:0]   cfg_acc_base;
  logic [ACC_AW-1:0]   cfg_acc_stride;
  logic                cfg_zero;
  logic                busy;
  logic                done;
  logic                inp_en;
  logic [INP_AW-1:0]   inp_addr;
  logic                wgt_en;
  logic [WGT_AW-1:0]   wgt_addr;
  logic                acc_rd_en;
  logic [ACC_AW-1:0]   acc_rd_addr;
  logic [AT_WIDTH-1:0] acc_rd_data;
  logic [AT_WIDTH-1:0] gemm_a_tensor;
  logic [AT_WIDTH-1:0] gemm_o_tensor;
  logic                acc_wr_en;
  logic [ACC_AW-1:0]   acc_wr_addr;
  logic [AT_WIDTH-1:0] acc_wr_data;

  modport slave (
    input  start, cfg_iters, cfg_inp_base, cfg_inp_stride, cfg_wgt_base, cfg_wgt_stride,
           cfg_acc_base, cfg_acc_stride, cfg_zero, acc_rd_data, gemm_o_tensor,
    output busy, done, inp_en, inp_addr, wgt_en, wgt_addr, acc_rd_en, acc_rd_addr,
           gemm_a_tensor, acc_wr_en, acc_wr_addr, acc_wr_data
  );

  modport master (
    output start, cfg_iters, cfg_inp_base, cfg_inp_stride, cfg_wgt_base, cfg_wgt_stride,
           cfg_acc_base, cfg_acc_stride, cfg_zero, acc_rd_data, gemm_o_tensor,
    input  busy, done, inp_en, inp_addr, wgt_en, wgt_addr, acc_rd_en, acc_rd_addr,
           gemm_a_tensor, acc_wr_en, acc_wr_addr, acc_wr_data
  );
endinterface

// File: rtl/gemm_addr_gen.sv
// Base/stride address walker: load captures base and stride, step adds the stride.
// The sum is kept at AW bits so addresses wrap modulo the SRAM depth.
module gemm_addr_gen #(
  parameter int AW = 11
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load,
  input  logic          step,
  input  logic [AW-1:0] base,
  input  logic [AW-1:0] stride,
  output logic [AW-1:0] addr
);
  logic [AW-1:0] stride_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr     <= '0;
      stride_q <= '0;
    end else if (load) begin
      addr     <= base;
      stride_q <= stride;
    end else if (step) begin
      addr     <= addr + stride_q;
    end
  end
endmodule

// File: rtl/gemm_seq.sv
// GEMM sequencer: walks inp/wgt/acc SRAMs, feeds gemm_op the accumulator operand
// and writes o_tensor back, with read-after-write forwarding around the SRAM.
//   state    | meaning
//   ST_IDLE  | waiting for start, history cleared
//   ST_RUN   | issuing one iteration per cycle (stage 0)
//   ST_DRAIN | waiting for in-flight iterations to write back
//   ST_DONE  | one-cycle completion pulse
module gemm_seq #(
  parameter int ACC_WIDTH = gemm_pkg::ACC_WIDTH,
  parameter int BLOCK     = gemm_pkg::BLOCK,
  parameter int INP_AW    = gemm_pkg::INP_AW,
  parameter int WGT_AW    = gemm_pkg::WGT_AW,
  parameter int ACC_AW    = gemm_pkg::ACC_AW,
  parameter int CNT_W     = gemm_pkg::CNT_W,
  parameter int AT_WIDTH  = ACC_WIDTH * BLOCK
) (
  input  logic clk,
  input  logic rst_n,
  gemm_seq_if.slave bus
);
  import gemm_pkg::*;

  gemm_state_e         state;
  logic [CNT_W-1:0]    rem_q;
  logic                zero_q;
  logic                s0_v;
  logic                busy_q;
  logic                done_q;
  logic                s1_v;
  logic [ACC_AW-1:0]   s1_addr;
  logic                s2_v;
  logic [ACC_AW-1:0]   s2_addr;
  logic [AT_WIDTH-1:0] s2_data;
  logic                hist_v;
  logic [ACC_AW-1:0]   hist_addr;
  logic [AT_WIDTH-1:0] hist_data;
  logic [AT_WIDTH-1:0] fwd_data;
  logic [INP_AW-1:0]   inp_addr;
  logic [WGT_AW-1:0]   wgt_addr;
  logic [ACC_AW-1:0]   acc_addr;
  logic                load;
  logic                step;
  logic                last;

  assign load = (state == ST_IDLE) && bus.start;
  assign last = (rem_q == CNT_W'(1));
  assign step = (state == ST_RUN) && !last;

  gemm_addr_gen #(.AW(INP_AW)) u_inp_ag (
    .clk(clk), .rst_n(rst_n), .load(load), .step(step),
    .base(bus.cfg_inp_base), .stride(bus.cfg_inp_stride), .addr(inp_addr)
  );
  gemm_addr_gen #(.AW(WGT_AW)) u_wgt_ag (
    .clk(clk), .rst_n(rst_n), .load(load), .step(step),
    .base(bus.cfg_wgt_base), .stride(bus.cfg_wgt_stride), .addr(wgt_addr)
  );
  gemm_addr_gen #(.AW(ACC_AW)) u_acc_ag (
    .clk(clk), .rst_n(rst_n), .load(load), .step(step),
    .base(bus.cfg_acc_base), .stride(bus.cfg_acc_stride), .addr(acc_addr)
  );

  // An empty run goes through DRAIN so done lands two cycles after start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= ST_IDLE;
      rem_q  <= '0;
      zero_q <= 1'b0;
      s0_v   <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.start) begin
            rem_q  <= bus.cfg_iters;
            zero_q <= bus.cfg_zero;
            busy_q <= 1'b1;
            if (bus.cfg_iters != '0) begin
              state <= ST_RUN;
              s0_v  <= 1'b1;
            end else begin
              state <= ST_DRAIN;
            end
          end
        end
        ST_RUN: begin
          if (last) begin
            state <= ST_DRAIN;
            s0_v  <= 1'b0;
          end else begin
            rem_q <= rem_q - CNT_W'(1);
          end
        end
        ST_DRAIN: begin
          if (!s1_v && !s2_v) begin
            state  <= ST_DONE;
            done_q <= 1'b1;
          end
        end
        ST_DONE: begin
          state  <= ST_IDLE;
          done_q <= 1'b0;
          busy_q <= 1'b0;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_v      <= 1'b0;
      s1_addr   <= '0;
      s2_v      <= 1'b0;
      s2_addr   <= '0;
      s2_data   <= '0;
      hist_v    <= 1'b0;
      hist_addr <= '0;
      hist_data <= '0;
    end else begin
      s1_v <= s0_v;
      if (s0_v) s1_addr <= acc_addr;
      s2_v <= s1_v;
      if (s1_v) begin
        s2_addr <= s1_addr;
        s2_data <= bus.gemm_o_tensor;
      end
      hist_v <= s2_v && (state != ST_IDLE);
      if (s2_v) begin
        hist_addr <= s2_addr;
        hist_data <= s2_data;
      end
    end
  end

  // The SRAM is read-first: writes in the read cycle and the one before it are not visible.
  always_comb begin
    fwd_data = bus.acc_rd_data;
    if (hist_v && (s1_addr == hist_addr)) fwd_data = hist_data;
    if (s2_v && (s1_addr == s2_addr)) fwd_data = s2_data;
  end

  assign bus.gemm_a_tensor = (s1_v && !zero_q) ? fwd_data : '0;
  assign bus.busy          = busy_q;
  assign bus.done          = done_q;
  assign bus.inp_en        = s0_v;
  assign bus.inp_addr      = inp_addr;
  assign bus.wgt_en        = s0_v;
  assign bus.wgt_addr      = wgt_addr;
  assign bus.acc_rd_en     = s0_v && !zero_q;
  assign bus.acc_rd_addr   = acc_addr;
  assign bus.acc_wr_en     = s2_v;
  assign bus.acc_wr_addr   = s2_addr;
  assign bus.acc_wr_data   = s2_data;
endmodule
